multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle control FSM that sequences the shared RV32I datapath: one memory, one ALU, register file, and the IR/PC/ALUOut/Data registers.
- Executes one instruction over 3–5 states, plus optional memory wait states.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Sits between the instruction register fields and the datapath select/enable lines. It is the sequential replacement for the single-cycle control unit.

Parameters:
- MEM_LATENCY, 0, extra wait cycles spent in FETCH and MEMREAD before memory data is valid (range 0–15).
- ALUCTRL_W, 3, width of alu_control; matches the existing ALU encoding.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write enable.
- ir_write  out  1  IR and OldPC load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  Result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- alu_src_b  out  2  SrcB select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  ALUCTRL_W  ALU operation: add 000, sub 001, and 010, or 011, slt 101.
- state_o  out  4  current state, for debug and bench visibility.

Behaviour:
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11 (TRAP exists only with the optional feature).
- Reset: state = FETCH, wait counter = 0.
  - All enables (pc_write, ir_write, reg_write, mem_write) are 0 while rst is high.
  - All other outputs take their FETCH decode.
  - Reset asserted mid-instruction aborts it immediately; there are no partial writes after rst rises.
- Outputs are Moore-decoded from the state, except:
  - pc_write = pc_update | (branch & zero);
  - alu_control also depends on funct3/op/funct7b5;
  - imm_src is decoded combinationally from op: lw/I-type 00, sw 01, beq 10, jal 11, others 00.
- Per-state outputs (any select not listed is 00, any enable not listed is 0):
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, aluop=add, result_src=10; ir_write and pc_update asserted on the last FETCH cycle only.
  - DECODE: alu_src_a=01, alu_src_b=01, aluop=add (precomputes the branch/jump target).
  - MEMADR: alu_src_a=10, alu_src_b=01, aluop=add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWRITE: adr_src=1, mem_write=1.
  - MEMWB: result_src=01, reg_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, aluop=funct.
  - EXECI: alu_src_a=10, alu_src_b=01, aluop=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, aluop=sub, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, aluop=add, result_src=00, pc_update=1; then ALUWB writes rd = PC+4.
- Transitions:
  - FETCH → DECODE once the wait counter reaches MEM_LATENCY.
  - DECODE → next state by op:
    - 0000011 or 0100011 → MEMADR;
    - 0110011 → EXECR;
    - 0010011 → EXECI;
    - 1100011 → BEQ;
    - 1101111 → JAL;
    - any other op → illegal handling (see Optional Feature).
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB once the wait counter reaches MEM_LATENCY.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Wait counter:
  - Increments in FETCH/MEMREAD while below MEM_LATENCY.
  - Clears on every state change.
  - With MEM_LATENCY=0, FETCH and MEMREAD each take one cycle.
- Cycles per instruction (MEM_LATENCY=0): lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- ALU decode (alu_control):
  - aluop add → 000; aluop sub → 001.
  - aluop funct, by funct3:
    - 000 → sub if (op[5] & funct7b5), else add;
    - 010 → slt;
    - 110 → or;
    - 111 → and;
    - any other funct3 → add (000).
- No combinational path from any input to ir_write, mem_write or reg_write.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported op in DECODE → TRAP.
  - TRAP holds with all enables 0 and an extra output port illegal_o=1.
  - Only rst leaves TRAP.
- Undefined:
  - An unsupported op is a NOP: DECODE → FETCH with no writes.
  - The PC has already advanced in FETCH, so execution continues at the next instruction.
  - The illegal_o port does not exist.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum (4-bit);
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - aluop enum (ADD, SUB, FUNCT);
  - alu_control codes;
  - select encodings for adr_src, result_src, alu_src_a, alu_src_b and imm_src.
- One sub-module, mc_alu_decoder: purely combinational, maps (aluop, funct3, op5, funct7b5) to alu_control.
- The FSM, wait counter and output decode remain in multicycle_controller.

Test Plan:
- rst pulsed mid-MEMWRITE (rst rising while state_o=5) → state_o=0 and mem_write=0 in the same cycle, before the next clk edge.
- lw (op=0000011), MEM_LATENCY=0 → state_o sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; ir_write/pc_write high only in state 0.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → states 0,1,6,8,0; alu_control=001 in state 6; reg_write=1 in state 8.
- beq with zero=1 → pc_write=1 in state 9, alu_control=001; beq with zero=0 → pc_write=0 in state 9; both return to state 0 the next cycle.
- MEM_LATENCY=2, sw (op=0100011) → FETCH lasts 3 cycles with ir_write=1 only in the third; states 0,0,0,1,2,5,0; mem_write=1 in state 5 only; imm_src=01.
- op=1111111 → without MC_ILLEGAL_TRAP_EN: states 0,1,0 with no enables in state 1; with MC_ILLEGAL_TRAP_EN: state_o=11 held with illegal_o=1 until rst.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU ops and datapath selects.
// S_TRAP is only reachable when MC_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode: maps (aluop, funct3, op[5], funct7[5]) to the ALU operation code.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  aluop_e               aluop_i,
    input  logic [2:0]           funct3_i,
    input  logic                 op5_i,
    input  logic                 funct7b5_i,
    output logic [ALUCTRL_W-1:0] alu_control_o
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        unique case (aluop_i)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                // only R-type (op[5]=1) honours funct7[5]; addi never becomes sub
                case (funct3_i)
                    3'b000:  code = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  code = ALU_SLT;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory wait counter and Moore output decode.
// Define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes (adds illegal_o); otherwise they act as NOPs.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 0,
    parameter int unsigned ALUCTRL_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic                 illegal_o,
`endif
    output logic [3:0]           state_o
);

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    logic [3:0] state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       mem_done;
    logic       pc_update, branch;
    logic       ir_en, reg_en, mem_en;
    aluop_e     aluop;

    assign mem_done = (wait_q == LAT);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (mem_done) state_d = S_DECODE;
                else          wait_d  = wait_q + 4'd1;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_done) state_d = S_MEMWB;
                else          wait_d  = wait_q + 4'd1;
            end
            S_EXECR, S_EXECI, S_JAL:              state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:    state_d = S_TRAP;
`else
            S_TRAP:    state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        mem_en     = 1'b0;
        adr_src    = ADR_PC;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_en      = mem_done;
                pc_update  = mem_done;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = ADR_ALUOUT;
            S_MEMWRITE: begin
                adr_src = ADR_ALUOUT;
                mem_en  = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_en     = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: reg_en = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are forced low for the whole reset pulse, including the async-reset FETCH
    assign pc_write  = (pc_update | (branch & zero)) & ~rst;
    assign ir_write  = ir_en & ~rst;
    assign reg_write = reg_en & ~rst;
    assign mem_write = mem_en & ~rst;

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

    mc_alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_dec (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .op5_i        (op[5]),
        .funct7b5_i   (funct7b5),
        .alu_control_o(alu_control)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_o = (state_q == S_TRAP);
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: two controllers (MEM_LATENCY 0 and 2) checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       rst_a, rst_b, zero_a, zero_b;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;

    logic       pcw_a, adr_a, mw_a, irw_a, rw_a;
    logic [1:0] rs_a, sa_a, sb_a, imm_a;
    logic [2:0] alu_a;
    logic [3:0] st_a;
    logic       pcw_b, adr_b, mw_b, irw_b, rw_b;
    logic [1:0] rs_b, sa_b, sb_b, imm_b;
    logic [2:0] alu_b;
    logic [3:0] st_b;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       ill_a, ill_b;
`endif

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_LATENCY(0), .ALUCTRL_W(3)) dut_a (
        .clk(clk), .rst(rst_a), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero_a),
        .pc_write(pcw_a), .adr_src(adr_a), .mem_write(mw_a), .ir_write(irw_a), .reg_write(rw_a),
        .result_src(rs_a), .alu_src_a(sa_a), .alu_src_b(sb_a), .imm_src(imm_a), .alu_control(alu_a),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_o(ill_a),
`endif
        .state_o(st_a)
    );

    multicycle_controller #(.MEM_LATENCY(2), .ALUCTRL_W(3)) dut_b (
        .clk(clk), .rst(rst_b), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero_b),
        .pc_write(pcw_b), .adr_src(adr_b), .mem_write(mw_b), .ir_write(irw_b), .reg_write(rw_b),
        .result_src(rs_b), .alu_src_a(sa_b), .alu_src_b(sb_b), .imm_src(imm_b), .alu_control(alu_b),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_o(ill_b),
`endif
        .state_o(st_b)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (st/pcw/irw/rw/mw/adr/res/sa/sb/imm/alu)", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec(input int sel);
        logic ill;
        ill = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        ill = (sel == 0) ? ill_a : ill_b;
`endif
        if (sel == 0)
            return {11'd0, ill, st_a, pcw_a, irw_a, rw_a, mw_a, adr_a, rs_a, sa_a, sb_a, imm_a, alu_a};
        return {11'd0, ill, st_b, pcw_b, irw_b, rw_b, mw_b, adr_b, rs_b, sa_b, sb_b, imm_b, alu_b};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Expected outputs from the per-state table; 'last' marks the final FETCH cycle.
    function automatic logic [31:0] exp_vec(input int st, input bit last, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z,
                                            input bit in_rst);
        logic       pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, imm = 0;
        logic [2:0] alu = 0, fa;
        if (o == 7'b0100011)      imm = 2'd1;
        else if (o == 7'b1100011) imm = 2'd2;
        else if (o == 7'b1101111) imm = 2'd3;
        if (f3 == 3'd0)      fa = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'd2) fa = 3'b101;
        else if (f3 == 3'd6) fa = 3'b011;
        else if (f3 == 3'd7) fa = 3'b010;
        else                 fa = 3'b000;
        case (st)
            0:  begin rs = 2; sb = 2; irw = last; pcw = last; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = fa; end
            7:  begin sa = 2; sb = 1; alu = fa; end
            8:  rw = 1;
            9:  begin sa = 2; alu = 3'b001; pcw = z; end
            10: begin sa = 1; sb = 2; pcw = 1; end
            11: ill = 1;
            default: ;
        endcase
        if (in_rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {11'd0, ill, 4'(st), pcw, irw, rw, mw, adr, rs, sa, sb, imm, alu};
    endfunction

    // Instruction-level schedule: entries are state*2 + last-fetch flag.
    function automatic q_t build_seq(input int lat, input logic [6:0] o);
        q_t q;
        for (int i = 0; i <= lat; i++) q.push_back(i == lat ? 1 : 0);
        q.push_back(2);
        case (o)
            7'b0000011: begin
                q.push_back(4);
                for (int i = 0; i <= lat; i++) q.push_back(6);
                q.push_back(8);
            end
            7'b0100011: begin q.push_back(4); q.push_back(10); end
            7'b0110011: begin q.push_back(12); q.push_back(16); end
            7'b0010011: begin q.push_back(14); q.push_back(16); end
            7'b1100011: q.push_back(18);
            7'b1101111: begin q.push_back(20); q.push_back(16); end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) q.push_back(22);
                return q;
`endif
            end
        endcase
        q.push_back(lat == 0 ? 1 : 0);
        return q;
    endfunction

    task automatic set_ctl(input int sel, input logic r, input logic z);
        if (sel == 0) begin rst_a = r; zero_a = z; end
        else          begin rst_b = r; zero_b = z; end
    endtask

    // abort_at: -1 none, -2 random cycle, >=0 that cycle index
    task automatic run_inst(input int sel, input int lat, input int abort_at);
        q_t   q;
        int   ab;
        logic z;
        q  = build_seq(lat, op);
        ab = (abort_at == -2) ? int'($urandom_range(0, q.size() - 1)) : abort_at;
        @(negedge clk);
        set_ctl(sel, 1'b1, 1'b0);
        #1 expect_eq("reset", obs_vec(sel), exp_vec(0, lat == 0, op, funct3, funct7b5, 1'b0, 1'b1));
        @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            if (k > 0) @(negedge clk);
            z = 1'($urandom_range(0, 1));
            set_ctl(sel, 1'b0, z);
            #1;
            if (k == ab) begin
                set_ctl(sel, 1'b1, z);
                #1 expect_eq("abort", obs_vec(sel), exp_vec(0, lat == 0, op, funct3, funct7b5, z, 1'b1));
                break;
            end
            expect_eq(sel == 0 ? "cycle_lat0" : "cycle_lat2", obs_vec(sel),
                      exp_vec(q[k] >> 1, q[k][0], op, funct3, funct7b5, z, 1'b0));
        end
    endtask

    task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int ab_a, input int ab_b);
        op = o; funct3 = f3; funct7b5 = f7;
        fork
            run_inst(0, 0, ab_a);
            run_inst(1, 2, ab_b);
        join
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] o;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        rst_a = 1'b1; rst_b = 1'b1; zero_a = 1'b0; zero_b = 1'b0;
        op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0;
        repeat (2) @(negedge clk);

        apply(7'b0100011, 3'd2, 1'b0, 3, 5);   // reset while in MEMWRITE
        apply(7'b0000011, 3'd2, 1'b0, -1, -1);
        apply(7'b0110011, 3'd0, 1'b1, -1, -1);
        apply(7'b1100011, 3'd0, 1'b0, -1, -1);
        apply(7'b0100011, 3'd2, 1'b0, -1, -1);
        apply(7'b1101111, 3'd5, 1'b1, -1, -1);
        apply(7'b1111111, 3'd0, 1'b0, -1, -1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                do o = 7'($urandom); while (is_legal(o));
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            apply(o, 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? -2 : -1,
                  ($urandom_range(0, 3) == 0) ? -2 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
